// File: rtl/accel_tilt_encoder_pkg.sv
// Shared definitions for the accelerometer tilt encoder: tilt word width and
// per-axis level encodings, also consumed by the regfile and LED/JA decode.
package accel_tilt_encoder_pkg;

    localparam int TILT_W = 4;

    typedef enum logic [1:0] {
        LVL_NEUTRAL = 2'd0,
        LVL_NEG     = 2'd1,
        LVL_POS     = 2'd2
    } level_e;

endpackage

// File: rtl/accel_tilt_encoder_axis_hysteresis.sv
// Per-axis tilt classifier: three-level hysteresis on the windowed mean.
// Flush forces NEUTRAL and takes priority over a mean arriving the same cycle.
module axis_hysteresis
    import accel_tilt_encoder_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int ENTER_TH = 200,
    parameter int EXIT_TH  = 120
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     mean_valid,
    input  logic signed [DATA_W:0]   mean,
    output logic [1:0]               level
);

    localparam logic signed [DATA_W:0] ENTER_P = (DATA_W + 1)'(ENTER_TH);
    localparam logic signed [DATA_W:0] ENTER_N = -ENTER_P;
    localparam logic signed [DATA_W:0] EXIT_P  = (DATA_W + 1)'(EXIT_TH);
    localparam logic signed [DATA_W:0] EXIT_N  = -EXIT_P;

    level_e state_q;
    level_e state_d;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= LVL_NEUTRAL;
        end else if (mean_valid) begin
            state_q <= state_d;
        end
    end

    // A strong opposite tilt jumps straight across without passing NEUTRAL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LVL_NEUTRAL: begin
                if (mean >= ENTER_P)      state_d = LVL_POS;
                else if (mean <= ENTER_N) state_d = LVL_NEG;
            end
            LVL_POS: begin
                if (mean <= ENTER_N)      state_d = LVL_NEG;
                else if (mean < EXIT_P)   state_d = LVL_NEUTRAL;
            end
            LVL_NEG: begin
                if (mean >= ENTER_P)      state_d = LVL_POS;
                else if (mean > EXIT_N)   state_d = LVL_NEUTRAL;
            end
            default: state_d = LVL_NEUTRAL;
        endcase
    end

    assign level = state_q;

endmodule

// File: rtl/accel_tilt_encoder.sv
// Accelerometer tilt encoder: windowed X/Y averaging, per-axis hysteresis,
// and a stale-data watchdog; publishes a 4-bit tilt code as a 32-bit word.
module accel_tilt_encoder
    import accel_tilt_encoder_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int AVG_LOG2     = 3,
    parameter int ENTER_TH     = 200,
    parameter int EXIT_TH      = 120,
    parameter int STALE_CYCLES = 2000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic signed [DATA_W-1:0]  x_raw,
    input  logic signed [DATA_W-1:0]  y_raw,
    output logic [TILT_W-1:0]         tilt_code,
    output logic [31:0]               accel_word,
    output logic                      accel_valid,
    output logic                      stale
);

    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int IDLE_W = $clog2(STALE_CYCLES + 1);

    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic signed [ACC_W-1:0]  sum_x, sum_y;
    logic [AVG_LOG2-1:0]      cnt;
    logic [IDLE_W-1:0]        idle_cnt;
    logic                     wrap, timeout;
    logic signed [DATA_W:0]   mean_x_p0, mean_y_p0;
    logic                     vld_p0;
    logic [1:0]               level_x, level_y;

    // Floor division by the window size; the mean always fits DATA_W+1 bits.
    function automatic logic signed [DATA_W:0] window_mean(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] shifted;
        shifted = sum >>> AVG_LOG2;
        return shifted[DATA_W:0];
    endfunction

    assign sum_x   = acc_x + $signed({{AVG_LOG2{x_raw[DATA_W-1]}}, x_raw});
    assign sum_y   = acc_y + $signed({{AVG_LOG2{y_raw[DATA_W-1]}}, y_raw});
    assign wrap    = sample_valid && (cnt == '1);
    assign timeout = !sample_valid && (idle_cnt == IDLE_W'(STALE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_x       <= '0;
            acc_y       <= '0;
            cnt         <= '0;
            idle_cnt    <= '0;
            stale       <= 1'b1;
            vld_p0      <= 1'b0;
            accel_valid <= 1'b0;
        end else begin
            accel_valid <= vld_p0 || timeout;
            if (sample_valid) begin
                idle_cnt <= '0;
                stale    <= 1'b0;
                vld_p0   <= wrap;
                cnt      <= cnt + 1'b1;
                if (wrap) begin
                    acc_x <= '0;
                    acc_y <= '0;
                end else begin
                    acc_x <= sum_x;
                    acc_y <= sum_y;
                end
            end else begin
                vld_p0 <= 1'b0;
                if (idle_cnt != IDLE_W'(STALE_CYCLES)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (timeout) begin
                    stale <= 1'b1;
                    acc_x <= '0;
                    acc_y <= '0;
                    cnt   <= '0;
                end
            end
        end
    end

    // p0: window mean registered on the cycle after the last sample of the window
    always_ff @(posedge clock) begin
        if (wrap) begin
            mean_x_p0 <= window_mean(sum_x);
            mean_y_p0 <= window_mean(sum_y);
        end
    end

    // p1: level registers inside the classifiers; tilt code is read straight from them
    axis_hysteresis #(
        .DATA_W   (DATA_W),
        .ENTER_TH (ENTER_TH),
        .EXIT_TH  (EXIT_TH)
    ) u_hyst_x (
        .clock      (clock),
        .reset      (reset),
        .flush      (timeout),
        .mean_valid (vld_p0),
        .mean       (mean_x_p0),
        .level      (level_x)
    );

    axis_hysteresis #(
        .DATA_W   (DATA_W),
        .ENTER_TH (ENTER_TH),
        .EXIT_TH  (EXIT_TH)
    ) u_hyst_y (
        .clock      (clock),
        .reset      (reset),
        .flush      (timeout),
        .mean_valid (vld_p0),
        .mean       (mean_y_p0),
        .level      (level_y)
    );

    assign tilt_code  = {level_y, level_x};
    assign accel_word = {{(32 - TILT_W){1'b0}}, tilt_code};

endmodule

// File: tb/tb_accel_tilt_encoder.sv
// Scoreboard bench for accel_tilt_encoder: stimulus queues expected tilt/stale
// values, a negedge monitor pops one entry per accel_valid pulse.
module tb_accel_tilt_encoder;

    logic               clock = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [11:0] x_raw, y_raw;
    logic [3:0]         tilt_code;
    logic [31:0]        accel_word;
    logic               accel_valid;
    logic               stale;

    typedef struct packed {
        logic [3:0] code;
        logic       stl;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;
    int   pc_snap;

    always #5 clock = ~clock;

    accel_tilt_encoder #(.STALE_CYCLES(100)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .x_raw        (x_raw),
        .y_raw        (y_raw),
        .tilt_code    (tilt_code),
        .accel_word   (accel_word),
        .accel_valid  (accel_valid),
        .stale        (stale)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && accel_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual code=%0h required=no pulse", tilt_code);
            end else begin
                exp_cur = exp_q.pop_front();
                check("tilt_code", 32'(tilt_code), 32'(exp_cur.code));
                check("accel_word", accel_word, {28'b0, exp_cur.code});
                check("stale_at_pulse", 32'(stale), 32'(exp_cur.stl));
            end
        end
    end

    task automatic send(input int x, input int y);
        sample_valid = 1'b1;
        x_raw        = 12'(x);
        y_raw        = 12'(y);
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic window(input int x, input int y, input logic [3:0] code);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(exp_t'{code, 1'b0});
            send(x, y);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        x_raw        = '0;
        y_raw        = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_tilt_code", 32'(tilt_code), 32'h0);
        check("rst_accel_word", accel_word, 32'h0);
        check("rst_accel_valid", 32'(accel_valid), 32'h0);
        check("rst_stale", 32'(stale), 32'h1);

        // x=+300 window: POS on X, pulse exactly two clocks after the 8th sample
        for (int i = 0; i < 7; i++) send(300, 0);
        exp_q.push_back(exp_t'{4'b0010, 1'b0});
        send(300, 0);
        check("t1_no_early_pulse", 32'(accel_valid), 32'h0);
        idle(1);
        check("t1_pulse_latency", 32'(accel_valid), 32'h1);
        idle(2);

        // hysteresis on X: 300 stays, 150 holds POS, 100 drops to NEUTRAL
        window(300, 0, 4'b0010); idle(3);
        window(150, 0, 4'b0010); idle(3);
        window(100, 0, 4'b0000); idle(3);

        // Y: -200 enters NEG inclusively, -121 holds NEG, -119 leaves
        window(0, -200, 4'b0100); idle(3);
        window(0, -121, 4'b0100); idle(3);
        window(0, -119, 4'b0000); idle(3);

        // mean -7 stays neutral; the extra -1 opens the next window with no gap,
        // and -1597/8 floors to -200 (truncation would give -199 and stay neutral)
        window(-7, 0, 4'b0000);
        send(-1, 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) exp_q.push_back(exp_t'{4'b0001, 1'b0});
            send(-228, 0);
        end
        idle(3);

        // 32 back-to-back samples, X alternating +400/-400 per window
        for (int w = 0; w < 4; w++) begin
            if (w % 2 == 0) window(400, 0, 4'b0010);
            else            window(-400, 0, 4'b0001);
        end
        idle(3);

        // hold POS, then starve the input until the watchdog fires once
        window(400, 0, 4'b0010);
        idle(3);
        exp_q.push_back(exp_t'{4'b0000, 1'b1});
        idle(110);
        check("t6_stale_set", 32'(stale), 32'h1);
        check("t6_tilt_cleared", 32'(tilt_code), 32'h0);
        send(400, 0);
        check("t6_stale_cleared", 32'(stale), 32'h0);
        send(400, 0);
        send(400, 0);

        // reset mid-window discards the 3 pending samples
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        pc_snap = pulses;
        for (int i = 0; i < 7; i++) send(400, 0);
        idle(4);
        check("t6_partial_discarded", 32'(pulses), 32'(pc_snap));
        exp_q.push_back(exp_t'{4'b0010, 1'b0});
        send(400, 0);
        idle(4);
        check("t6_full_window_pulse", 32'(pulses), 32'(pc_snap + 1));
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
